morra_match_ctrl: RTL
=====================

MORRA_MATCH_CTRL -- requirements
Module: morra_match_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge system clock.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: INIZIA  in  1  start/configure match; config value on {PRIMO,SECONDO}.
REQ-004 SHALL have port: PRIMO  in  2  player-1 move (00 none, 01 sasso, 10 carta, 11 forbice).
REQ-005 SHALL have port: PRIMO_VALID  in  1  player-1 move strobe.
REQ-006 SHALL have port: SECONDO  in  2  player-2 move, same encoding.
REQ-007 SHALL have port: SECONDO_VALID  in  1  player-2 move strobe.
REQ-008 SHALL have port: MANCHE  out  2  round result (00 invalid, 01 P1, 10 P2, 11 draw).
REQ-009 SHALL have port: MANCHE_VALID  out  1  one-cycle pulse qualifying MANCHE.
REQ-010 SHALL have port: PARTITA  out  2  match result (00 none, 01 P1, 10 P2, 11 draw), held.
REQ-011 SHALL have port: FINE  out  1  high while match over.
REQ-012 SHALL have port: NUM_MANCHE  out  5  counted rounds in current match.
REQ-013 SHALL have parameter: MIN_MANCHE, 4, rounds before a lead can end the match.

Function
REQ-014 SHALL implement states IDLE, WAIT_MOVES, JUDGE, OVER.
REQ-015 IDLE: SHALL ignore strobes; INIZIA=1 -> latch max_manche = {PRIMO,SECONDO}+4 (range 4..19), clear counters/block, go WAIT_MOVES.
REQ-016 INIZIA=1 in any state SHALL restart as REQ-015, clear PARTITA/FINE/NUM_MANCHE, override any same-cycle strobe.
REQ-017 WAIT_MOVES: each player's move SHALL be latched on its first VALID; later strobes from that player ignored until judged.
REQ-018 Both latched (same or different cycles) -> JUDGE next cycle; MANCHE/MANCHE_VALID registered, 1 cycle after the later latch.
REQ-019 Winner rule: carta beats sasso, sasso beats forbice, forbice beats carta; equal moves -> 11.
REQ-020 Any latched move 00 -> MANCHE=00, not counted, block unchanged.
REQ-021 Block: previous round winner replaying its winning move -> MANCHE=00, not counted, block kept.
REQ-022 Valid win SHALL record winner and winning move as new block; draw SHALL clear block.
REQ-023 Counted round (01/10/11) SHALL increment NUM_MANCHE; 01/10 increment 5-bit win counter of that player.
REQ-024 After JUDGE: end if NUM_MANCHE>=MIN_MANCHE and |w1-w2|>=2 (winner), else if NUM_MANCHE==max_manche (more wins, equal -> 11); else WAIT_MOVES.
REQ-025 Match end SHALL set PARTITA and FINE in same cycle as deciding MANCHE_VALID, enter OVER.
REQ-026 OVER: strobes ignored; PARTITA/FINE/NUM_MANCHE held until INIZIA or reset.
REQ-027 Win subtraction SHALL be signed or compare-ordered; no wrap-around false lead.

Reset
REQ-028 rst_n=0 at clk edge SHALL force IDLE, MANCHE=00, MANCHE_VALID=0, PARTITA=00, FINE=0, NUM_MANCHE=0, latches/block/counters clear, max_manche=4.
REQ-029 Reset SHALL override INIZIA and strobes, including mid-round with one move latched.

Structure
REQ-030 Package morra_pkg SHALL hold move/result encodings, state enum, MIN_MANCHE=4, MAX_MANCHE=19.
REQ-031 Round judging SHALL be sub-module morra_judge (combinational: two moves + block -> result).

Verification
REQ-032 INIZIA cfg 0000; P1 sasso/P2 forbice x2, then P1 carta/P2 sasso, then P1 forbice/P2 carta -> MANCHE 01,00(blocked),01,01; PARTITA=01 at count 3? no: count 3 <4, next draw -> PARTITA=01, FINE=1, NUM_MANCHE=4.
REQ-033 cfg 0000; four draws (sasso/sasso) -> NUM_MANCHE=4, PARTITA=11 at 4th MANCHE_VALID.
REQ-034 PRIMO_VALID cycle 0, SECONDO_VALID cycle 3, extra PRIMO_VALID cycle 2 -> first P1 move used, MANCHE_VALID cycle 4 only.
REQ-035 Move 00 from P2 -> MANCHE=00, NUM_MANCHE unchanged.
REQ-036 P1 latched, rst_n=0 one cycle, then P2 strobe -> no MANCHE_VALID; all outputs 0.
REQ-037 INIZIA with both strobes same cycle mid-match -> restart, strobes dropped, NUM_MANCHE=0.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings, FSM state type and match-length limits for the morra match controller.
// Imported by the judge and the top-level controller.
package morra_pkg;

    typedef enum logic [1:0] {
        MoveNone    = 2'b00,
        MoveSasso   = 2'b01,
        MoveCarta   = 2'b10,
        MoveForbice = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        ResInvalid = 2'b00,
        ResP1      = 2'b01,
        ResP2      = 2'b10,
        ResDraw    = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMoves,
        StJudge,
        StOver
    } state_e;

    localparam int unsigned MIN_MANCHE = 4;
    localparam int unsigned MAX_MANCHE = 19;

    function automatic logic beats(move_e a, move_e b);
        return ((a == MoveCarta)   && (b == MoveSasso))   ||
               ((a == MoveSasso)   && (b == MoveForbice)) ||
               ((a == MoveForbice) && (b == MoveCarta));
    endfunction

endpackage

// File: rtl/morra_match_ctrl_if.sv
// Player/referee bus of the morra match controller: moves and start in, round/match results out.
// The master side drives moves and start; the slave side is the controller.
interface morra_match_ctrl_if;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic       PRIMO_VALID;
    logic [1:0] SECONDO;
    logic       SECONDO_VALID;
    logic [1:0] MANCHE;
    logic       MANCHE_VALID;
    logic [1:0] PARTITA;
    logic       FINE;
    logic [4:0] NUM_MANCHE;

    modport master (
        output INIZIA, PRIMO, PRIMO_VALID, SECONDO, SECONDO_VALID,
        input  MANCHE, MANCHE_VALID, PARTITA, FINE, NUM_MANCHE
    );

    modport slave (
        input  INIZIA, PRIMO, PRIMO_VALID, SECONDO, SECONDO_VALID,
        output MANCHE, MANCHE_VALID, PARTITA, FINE, NUM_MANCHE
    );
endinterface

// File: rtl/morra_judge.sv
// Combinational round referee: two latched moves plus the current block give the round result.
// A none move, or the previous winner replaying its winning move, voids the round.
module morra_judge
    import morra_pkg::*;
(
    input  move_e   p1_move_i,
    input  move_e   p2_move_i,
    input  result_e block_who_i,
    input  move_e   block_move_i,
    output result_e result_o
);

    always_comb begin
        result_o = ResInvalid;
        if ((p1_move_i == MoveNone) || (p2_move_i == MoveNone)) begin
            result_o = ResInvalid;
        end else if ((block_who_i == ResP1) && (p1_move_i == block_move_i)) begin
            result_o = ResInvalid;
        end else if ((block_who_i == ResP2) && (p2_move_i == block_move_i)) begin
            result_o = ResInvalid;
        end else if (p1_move_i == p2_move_i) begin
            result_o = ResDraw;
        end else if (beats(p1_move_i, p2_move_i)) begin
            result_o = ResP1;
        end else begin
            result_o = ResP2;
        end
    end

endmodule

// File: rtl/morra_match_ctrl.sv
// Morra match controller: latches one move per player, judges the round, keeps score and
// declares the match result on a two-win lead (after MIN_MANCHE rounds) or at the round limit.
module morra_match_ctrl #(
    parameter int unsigned MIN_MANCHE = morra_pkg::MIN_MANCHE
) (
    input logic               clk,
    input logic               rst_n,
    morra_match_ctrl_if.slave bus
);
    import morra_pkg::*;

    state_e     state_q, state_d;
    move_e      p1_move_q, p1_move_d, p2_move_q, p2_move_d;
    logic       p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    result_e    block_who_q, block_who_d;
    move_e      block_move_q, block_move_d;
    logic [4:0] w1_q, w1_d, w2_q, w2_d;
    logic [4:0] num_q, num_d, max_q, max_d;
    result_e    manche_q, manche_d, partita_q, partita_d;
    logic       manche_valid_q, manche_valid_d, fine_q, fine_d;
    result_e    judge_res;

    morra_judge u_judge (
        .p1_move_i   (p1_move_q),
        .p2_move_i   (p2_move_q),
        .block_who_i (block_who_q),
        .block_move_i(block_move_q),
        .result_o    (judge_res)
    );

    always_comb begin
        state_d        = state_q;
        p1_move_d      = p1_move_q;
        p2_move_d      = p2_move_q;
        p1_vld_d       = p1_vld_q;
        p2_vld_d       = p2_vld_q;
        block_who_d    = block_who_q;
        block_move_d   = block_move_q;
        w1_d           = w1_q;
        w2_d           = w2_q;
        num_d          = num_q;
        max_d          = max_q;
        manche_d       = manche_q;
        manche_valid_d = 1'b0;
        partita_d      = partita_q;
        fine_d         = fine_q;

        unique case (state_q)
            StIdle: ;
            StWaitMoves: begin
                if (!p1_vld_q && bus.PRIMO_VALID) begin
                    p1_vld_d  = 1'b1;
                    p1_move_d = move_e'(bus.PRIMO);
                end
                if (!p2_vld_q && bus.SECONDO_VALID) begin
                    p2_vld_d  = 1'b1;
                    p2_move_d = move_e'(bus.SECONDO);
                end
                if (p1_vld_d && p2_vld_d) state_d = StJudge;
            end
            StJudge: begin
                manche_d       = judge_res;
                manche_valid_d = 1'b1;
                p1_vld_d       = 1'b0;
                p2_vld_d       = 1'b0;
                p1_move_d      = MoveNone;
                p2_move_d      = MoveNone;
                state_d        = StWaitMoves;
                if (judge_res != ResInvalid) begin
                    num_d = num_q + 5'd1;
                    if (judge_res == ResP1) begin
                        w1_d         = w1_q + 5'd1;
                        block_who_d  = ResP1;
                        block_move_d = p1_move_q;
                    end else if (judge_res == ResP2) begin
                        w2_d         = w2_q + 5'd1;
                        block_who_d  = ResP2;
                        block_move_d = p2_move_q;
                    end else begin
                        block_who_d  = ResInvalid;
                        block_move_d = MoveNone;
                    end
                end
                // Lead compared on zero-extended operands so a deficit can never wrap into a lead.
                if ((num_d >= 5'(MIN_MANCHE)) && ({1'b0, w1_d} >= ({1'b0, w2_d} + 6'd2))) begin
                    partita_d = ResP1;
                end else if ((num_d >= 5'(MIN_MANCHE)) &&
                             ({1'b0, w2_d} >= ({1'b0, w1_d} + 6'd2))) begin
                    partita_d = ResP2;
                end else if (num_d == max_q) begin
                    partita_d = (w1_d > w2_d) ? ResP1 : (w2_d > w1_d) ? ResP2 : ResDraw;
                end
                if (partita_d != ResInvalid) begin
                    fine_d  = 1'b1;
                    state_d = StOver;
                end
            end
            StOver: ;
            default: state_d = StIdle;
        endcase

        // Start wins over everything in the same cycle, including move strobes.
        if (bus.INIZIA) begin
            state_d        = StWaitMoves;
            max_d          = 5'({bus.PRIMO, bus.SECONDO}) + 5'd4;
            p1_vld_d       = 1'b0;
            p2_vld_d       = 1'b0;
            p1_move_d      = MoveNone;
            p2_move_d      = MoveNone;
            block_who_d    = ResInvalid;
            block_move_d   = MoveNone;
            w1_d           = 5'd0;
            w2_d           = 5'd0;
            num_d          = 5'd0;
            manche_d       = ResInvalid;
            manche_valid_d = 1'b0;
            partita_d      = ResInvalid;
            fine_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            p1_move_q      <= MoveNone;
            p2_move_q      <= MoveNone;
            p1_vld_q       <= 1'b0;
            p2_vld_q       <= 1'b0;
            block_who_q    <= ResInvalid;
            block_move_q   <= MoveNone;
            w1_q           <= 5'd0;
            w2_q           <= 5'd0;
            num_q          <= 5'd0;
            max_q          <= 5'd4;
            manche_q       <= ResInvalid;
            manche_valid_q <= 1'b0;
            partita_q      <= ResInvalid;
            fine_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            p1_move_q      <= p1_move_d;
            p2_move_q      <= p2_move_d;
            p1_vld_q       <= p1_vld_d;
            p2_vld_q       <= p2_vld_d;
            block_who_q    <= block_who_d;
            block_move_q   <= block_move_d;
            w1_q           <= w1_d;
            w2_q           <= w2_d;
            num_q          <= num_d;
            max_q          <= max_d;
            manche_q       <= manche_d;
            manche_valid_q <= manche_valid_d;
            partita_q      <= partita_d;
            fine_q         <= fine_d;
        end
    end

    assign bus.MANCHE       = manche_q;
    assign bus.MANCHE_VALID = manche_valid_q;
    assign bus.PARTITA      = partita_q;
    assign bus.FINE         = fine_q;
    assign bus.NUM_MANCHE   = num_q;

endmodule
